// File: rtl/fpga_robots_game_beeper.sv
// Multi-voice tone generator for the robots game: per-channel note commands,
// a three-stage mix pipeline and a first-order sigma-delta 1-bit audio output.
module fpga_robots_game_beeper #(
  parameter int NCH = 2,
  parameter int PW  = 16,
  parameter int AW  = 8,
  parameter int DW  = 16,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int MW = AW + CW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           dur_tick,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [CW-1:0]  cmd_ch,
  input  logic [PW-1:0]  cmd_freq,
  input  logic [AW-1:0]  cmd_vol,
  input  logic [1:0]     cmd_mode,
  input  logic [DW-1:0]  cmd_dur,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic [MW-1:0]  mix,
  output logic           audio_out
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD} ch_state_e;
  typedef enum logic [1:0] {M_SQUARE, M_TRI, M_SAW, M_NOISE} mode_e;

  ch_state_e     state_q [NCH];
  ch_state_e     state_d [NCH];
  logic [PW-1:0] freq_q  [NCH];
  logic [PW-1:0] phase_q [NCH];
  logic [PW:0]   sum     [NCH];
  logic [AW-1:0] vol_q   [NCH];
  mode_e         mode_q  [NCH];
  logic [DW-1:0] cnt_q   [NCH];
  logic [15:0]   lfsr_q  [NCH];
  logic [15:0]   lfsr_nx [NCH];
  logic [AW-1:0] wave    [NCH];
  logic [AW-1:0] s_q     [NCH];
  logic [AW-1:0] p_q     [NCH];
  logic [AW-1:0] p_d     [NCH];
  logic [NCH-1:0] ld;
  logic [NCH-1:0] expire;
  logic          accept;
  logic [MW-1:0] mix_d;
  logic [MW-1:0] acc_q;
  logic [MW:0]   sd_sum;

  assign accept = cmd_valid && cmd_ready;

  // Channel FSM next-state; a load always wins over an expiring countdown.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned and infers a latch.
      state_d[i] = state_q[i];
      ld[i]      = accept && (cmd_ch == CW'(i));
      expire[i]  = !ld[i] && dur_tick && (state_q[i] == S_PLAY) && (cnt_q[i] == DW'(1));
      if (ld[i]) begin
        if (cmd_dur == '0)      state_d[i] = S_IDLE;
        else if (cmd_dur == '1) state_d[i] = S_HOLD;
        else                    state_d[i] = S_PLAY;
      end else if (expire[i]) begin
        state_d[i] = S_IDLE;
      end
    end
  end

  // Phase adder, noise LFSR step and waveform shaping per voice.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sum[i]     = {1'b0, phase_q[i]} + {1'b0, freq_q[i]};
      lfsr_nx[i] = {lfsr_q[i][14:0],
                    lfsr_q[i][15] ^ lfsr_q[i][13] ^ lfsr_q[i][12] ^ lfsr_q[i][10]};
      wave[i]    = lfsr_q[i][AW-1:0];
      case (mode_q[i])
        M_SQUARE: wave[i] = {AW{phase_q[i][PW-1]}};
        M_TRI:    wave[i] = phase_q[i][PW-2 -: AW] ^ {AW{phase_q[i][PW-1]}};
        M_SAW:    wave[i] = phase_q[i][PW-1 -: AW];
        default:  wave[i] = lfsr_q[i][AW-1:0];
      endcase
      p_d[i] = (state_q[i] == S_IDLE) ? '0
             : AW'(((2 * AW)'(s_q[i]) * (2 * AW)'(vol_q[i])) >> AW);
    end
  end

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NCH; i++) mix_d = mix_d + MW'(p_q[i]);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_busy
    assign busy[g] = (state_q[g] != S_IDLE);
  end

  assign sd_sum = {1'b0, acc_q} + {1'b0, mix};

  // Voice control: command loading, duration countdown and phase advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      done      <= '0;
      // NOTE: the per-voice arrays are flops, not RAM, so they take the
      // async reset and every voice comes up silent with its own LFSR seed.
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_IDLE;
        freq_q[i]  <= '0;
        phase_q[i] <= '0;
        vol_q[i]   <= '0;
        mode_q[i]  <= M_SQUARE;
        cnt_q[i]   <= '0;
        lfsr_q[i]  <= 16'(i + 1);
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      cmd_ready <= !accept;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        done[i]    <= (ld[i] && (cmd_dur == '0)) || expire[i];
        if (ld[i]) begin
          freq_q[i]  <= cmd_freq;
          vol_q[i]   <= cmd_vol;
          mode_q[i]  <= mode_e'(cmd_mode);
          cnt_q[i]   <= cmd_dur;
          phase_q[i] <= '0;
        end else if (state_q[i] != S_IDLE) begin
          if ((state_q[i] == S_PLAY) && dur_tick) cnt_q[i] <= cnt_q[i] - DW'(1);
          if (tick) begin
            phase_q[i] <= sum[i][PW-1:0];
            if (sum[i][PW]) lfsr_q[i] <= lfsr_nx[i];
          end
        end
      end
    end
  end

  // Three-stage sample pipeline feeding the sigma-delta modulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        s_q[i] <= '0;
        p_q[i] <= '0;
      end
      mix       <= '0;
      acc_q     <= '0;
      audio_out <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        s_q[i] <= wave[i];
        p_q[i] <= p_d[i];
      end
      mix                <= mix_d;
      {audio_out, acc_q} <= sd_sum;
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_beeper.sv
// Directed bench for fpga_robots_game_beeper: reset, tones, expiry, density,
// retrigger, collision, handshake, noise, stop and out-of-range channels.
module tb_fpga_robots_game_beeper;

  localparam int NCH = 2;
  localparam int PW  = 16;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int CW  = 1;
  localparam int MW  = AW + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          dur_tick = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_ch = '0;
  logic [PW-1:0] cmd_freq = '0;
  logic [AW-1:0] cmd_vol = '0;
  logic [1:0]    cmd_mode = '0;
  logic [DW-1:0] cmd_dur = '0;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;
  logic [MW-1:0] mix;
  logic          audio_out;

  logic          cmd_valid3 = 1'b0;
  logic [1:0]    cmd_ch3 = '0;
  logic          cmd_ready3;
  logic [2:0]    busy3;
  logic [2:0]    done3;
  logic [9:0]    mix3;
  logic          audio3;

  int vectors = 0;
  int miscompares = 0;

  fpga_robots_game_beeper #(.NCH(NCH), .PW(PW), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .dur_tick(dur_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_freq(cmd_freq), .cmd_vol(cmd_vol), .cmd_mode(cmd_mode), .cmd_dur(cmd_dur),
    .busy(busy), .done(done), .mix(mix), .audio_out(audio_out)
  );

  // Three-voice instance so a channel code above NCH-1 is representable.
  fpga_robots_game_beeper #(.NCH(3), .PW(PW), .AW(AW), .DW(DW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .dur_tick(dur_tick),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_ch(cmd_ch3),
    .cmd_freq(cmd_freq), .cmd_vol(cmd_vol), .cmd_mode(cmd_mode), .cmd_dur(cmd_dur),
    .busy(busy3), .done(done3), .mix(mix3), .audio_out(audio3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    tick = 1'b0; dur_tick = 1'b0; cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one command for a single clock, returning at the next negedge.
  task automatic send(input logic [CW-1:0] ch, input logic [PW-1:0] f,
                      input logic [AW-1:0] v, input logic [1:0] m, input logic [DW-1:0] d);
    cmd_ch = ch; cmd_freq = f; cmd_vol = v; cmd_mode = m; cmd_dur = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int ones = 0;
    tick = 1'b0; dur_tick = 1'b0; cmd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (audio_out !== 1'b0) begin miscompares++; $display("FAIL reset_audio: got %b want 0", audio_out); end
    vectors++; if (mix !== '0) begin miscompares++; $display("FAIL reset_mix: got %0d want 0", mix); end
    vectors++; if (busy !== '0) begin miscompares++; $display("FAIL reset_busy: got %b want 00", busy); end
    vectors++; if (done !== '0) begin miscompares++; $display("FAIL reset_done: got %b want 00", done); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    rst_n = 1'b1;
    repeat (1000) begin @(negedge clk); ones += int'(audio_out); end
    vectors++; if (ones != 0) begin miscompares++; $display("FAIL quiet_audio: got %0d ones want 0", ones); end
  endtask

  task automatic test_square_expiry();
    logic [MW-1:0] exp_mix;
    do_reset();
    send(1'b0, 16'h4000, 8'd255, 2'd0, 16'd3);
    tick = 1'b1;
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk);
      exp_mix = (k >= 4 && ((k - 4) % 4) >= 2) ? MW'(254) : MW'(0);
      vectors++; if (mix !== exp_mix) begin miscompares++; $display("FAIL square_mix k=%0d: got %0d want %0d", k, mix, exp_mix); end
    end
    for (int n = 1; n <= 3; n++) begin
      dur_tick = 1'b1;
      @(negedge clk);
      dur_tick = 1'b0;
      vectors++; if (busy[0] !== (n < 3)) begin miscompares++; $display("FAIL square_busy n=%0d: got %b want %b", n, busy[0], n < 3); end
      vectors++; if (done[0] !== (n == 3)) begin miscompares++; $display("FAIL square_done n=%0d: got %b want %b", n, done[0], n == 3); end
      @(negedge clk);
      vectors++; if (done[0] !== 1'b0) begin miscompares++; $display("FAIL square_done_width n=%0d: got %b want 0", n, done[0]); end
    end
    @(negedge clk);
    vectors++; if (mix !== '0) begin miscompares++; $display("FAIL square_mix_after: got %0d want 0", mix); end
    tick = 1'b0;
  endtask

  task automatic test_density();
    int ones = 0;
    int bad_busy = 0;
    int dones = 0;
    do_reset();
    send(1'b0, 16'h8000, 8'd128, 2'd0, 16'hFFFF);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (mix !== MW'(127)) begin miscompares++; $display("FAIL density_mix: got %0d want 127", mix); end
    for (int c = 0; c < 512; c++) begin
      dur_tick = ((c % 16) == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      ones += int'(audio_out);
      if (busy[0] !== 1'b1) bad_busy++;
      if (done !== '0) dones++;
    end
    dur_tick = 1'b0;
    vectors++; if (ones != 127) begin miscompares++; $display("FAIL density_ones: got %0d want 127", ones); end
    vectors++; if (bad_busy != 0) begin miscompares++; $display("FAIL hold_busy: got %0d low cycles want 0", bad_busy); end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL hold_done: got %0d pulses want 0", dones); end
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== '0 || done !== '0 || mix !== '0 || audio_out !== 1'b0)
      begin miscompares++; $display("FAIL midnote_reset: got busy=%b done=%b mix=%0d audio=%b want 0", busy, done, mix, audio_out); end
    @(negedge clk);
    vectors++; if (done !== '0) begin miscompares++; $display("FAIL midnote_reset_done: got %b want 00", done); end
    rst_n = 1'b1;
  endtask

  task automatic test_retrigger();
    int dseen = 0;
    do_reset();
    send(1'b1, 16'h4000, 8'd255, 2'd2, 16'd100);
    tick = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b0;
    for (int n = 0; n < 10; n++) begin
      dur_tick = 1'b1;
      @(negedge clk);
      dur_tick = 1'b0;
      if (done !== '0) dseen++;
      @(negedge clk);
      if (done !== '0) dseen++;
    end
    vectors++; if (mix !== MW'(127)) begin miscompares++; $display("FAIL retrig_saw_mix: got %0d want 127", mix); end
    vectors++; if (dseen != 0 || busy[1] !== 1'b1) begin miscompares++; $display("FAIL retrig_first: got done=%0d busy=%b want 0,1", dseen, busy[1]); end
    send(1'b1, 16'h4000, 8'd255, 2'd2, 16'd2);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (done !== '0) dseen++;
    end
    vectors++; if (dseen != 0) begin miscompares++; $display("FAIL retrig_no_done: got %0d pulses want 0", dseen); end
    vectors++; if (mix !== '0) begin miscompares++; $display("FAIL retrig_phase: got %0d want 0", mix); end
    dur_tick = 1'b1;
    @(negedge clk);
    dur_tick = 1'b0;
    vectors++; if (done[1] !== 1'b0 || busy[1] !== 1'b1) begin miscompares++; $display("FAIL retrig_tick1: got done=%b busy=%b want 0,1", done[1], busy[1]); end
    @(negedge clk);
    dur_tick = 1'b1;
    @(negedge clk);
    dur_tick = 1'b0;
    vectors++; if (done[1] !== 1'b1 || busy[1] !== 1'b0) begin miscompares++; $display("FAIL retrig_tick2: got done=%b busy=%b want 1,0", done[1], busy[1]); end
  endtask

  task automatic test_collision();
    do_reset();
    send(1'b0, 16'h8000, 8'd255, 2'd0, 16'd2);
    dur_tick = 1'b1;
    @(negedge clk);
    dur_tick = 1'b1;
    send(1'b0, 16'h8000, 8'd255, 2'd0, 16'd5);
    dur_tick = 1'b0;
    vectors++; if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin miscompares++; $display("FAIL collide: got done=%b busy=%b want 0,1", done[0], busy[0]); end
    @(negedge clk);
    vectors++; if (done[0] !== 1'b0) begin miscompares++; $display("FAIL collide_next: got %b want 0", done[0]); end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (mix !== MW'(254)) begin miscompares++; $display("FAIL collide_plays: got %0d want 254", mix); end
    for (int n = 1; n <= 5; n++) begin
      dur_tick = 1'b1;
      @(negedge clk);
      dur_tick = 1'b0;
      vectors++; if (done[0] !== (n == 5)) begin miscompares++; $display("FAIL collide_dur n=%0d: got %b want %b", n, done[0], n == 5); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready0: got %b want 1", cmd_ready); end
    cmd_ch = 1'b0; cmd_freq = 16'h0100; cmd_vol = 8'd10; cmd_mode = 2'd1; cmd_dur = 16'hFFFF;
    cmd_valid = 1'b1;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b0 || busy !== 2'b01) begin miscompares++; $display("FAIL b2b_first: got ready=%b busy=%b want 0,01", cmd_ready, busy); end
    cmd_ch = 1'b1; cmd_dur = 16'd50;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1 || busy !== 2'b01) begin miscompares++; $display("FAIL b2b_gap: got ready=%b busy=%b want 1,01", cmd_ready, busy); end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++; if (cmd_ready !== 1'b0 || busy !== 2'b11) begin miscompares++; $display("FAIL b2b_second: got ready=%b busy=%b want 0,11", cmd_ready, busy); end
  endtask

  task automatic test_noise_stop();
    logic [15:0]   lf [1:24];
    logic [MW-1:0] exp_mix;
    lf[1] = 16'h0001;
    lf[2] = 16'h0001;
    for (int j = 3; j <= 24; j++)
      lf[j] = {lf[j-1][14:0], lf[j-1][15] ^ lf[j-1][13] ^ lf[j-1][12] ^ lf[j-1][10]};
    do_reset();
    send(1'b0, 16'hFFFF, 8'd255, 2'd3, 16'hFFFF);
    tick = 1'b1;
    for (int k = 2; k <= 24; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        exp_mix = MW'((int'(lf[k-3][7:0]) * 255) >> 8);
        vectors++; if (mix !== exp_mix) begin miscompares++; $display("FAIL noise_mix k=%0d: got %0d want %0d", k, mix, exp_mix); end
      end
    end
    tick = 1'b0;
    send(1'b0, 16'hFFFF, 8'd255, 2'd3, 16'd0);
    vectors++; if (busy[0] !== 1'b0 || done[0] !== 1'b1) begin miscompares++; $display("FAIL stop: got busy=%b done=%b want 0,1", busy[0], done[0]); end
    @(negedge clk);
    vectors++; if (done[0] !== 1'b0) begin miscompares++; $display("FAIL stop_width: got %b want 0", done[0]); end
  endtask

  task automatic test_ignored_channel();
    int dseen = 0;
    do_reset();
    cmd_ch3 = 2'd3; cmd_freq = 16'h8000; cmd_vol = 8'd255; cmd_mode = 2'd0; cmd_dur = 16'd5;
    vectors++; if (cmd_ready3 !== 1'b1) begin miscompares++; $display("FAIL ign_ready0: got %b want 1", cmd_ready3); end
    cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    vectors++; if (cmd_ready3 !== 1'b0 || busy3 !== 3'b000 || done3 !== 3'b000)
      begin miscompares++; $display("FAIL ign_accept: got ready=%b busy=%b done=%b want 0,000,000", cmd_ready3, busy3, done3); end
    tick = 1'b1;
    repeat (6) begin @(negedge clk); if (done3 !== '0) dseen++; end
    tick = 1'b0;
    vectors++; if (mix3 !== '0 || busy3 !== 3'b000 || dseen != 0)
      begin miscompares++; $display("FAIL ign_state: got mix=%0d busy=%b done=%0d want 0,000,0", mix3, busy3, dseen); end
    cmd_ch3 = 2'd2;
    cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    vectors++; if (busy3 !== 3'b100) begin miscompares++; $display("FAIL ign_real_ch: got %b want 100", busy3); end
  endtask

  initial begin
    test_reset();
    test_square_expiry();
    test_density();
    test_retrigger();
    test_collision();
    test_back_to_back();
    test_noise_stop();
    test_ignored_channel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
